jk_ff_bank: RTL and testbench
=============================

// Module: jk_ff_bank
// PURPOSE
//  Parametrised WIDTH-bit bank of universal edge-triggered flip-flops with a
//  runtime mode: JK, SR, D or T, common to all bits. Successor to the
//  single-bit JK flip-flop. Adds:
//   - synchronous reset to a parameter value, and a clock enable
//   - a registered per-bit change flag
//   - sticky SR-illegal error detection
//   - a saturating counter of cycles in which the bank changed
//  Serves as the general register primitive for lab datapaths (counters, shift chains).
// PARAMETERS
//  WIDTH      8      number of flip-flops in the bank (>=1)
//  RESET_VAL  0      WIDTH-bit value loaded into q on rst
//  CNT_W      8      width of chg_cnt (>=1)
// PORTS
//  clk      in   1        rising-edge clock
//  rst      in   1        synchronous reset, active-high
//  en       in   1        clock enable; 0 = hold all state except err_clr action
//  mode     in   2        00=JK 01=SR 10=D 11=T (sampled each edge)
//  a        in   WIDTH    J / S / D / T input per bit
//  b        in   WIDTH    K / R input per bit; ignored in D and T modes
//  err_clr  in   1        clears sr_err
//  q        out  WIDTH    flip-flop state
//  qb       out  WIDTH    always ~q, same cycle (no extra latency)
//  chg      out  WIDTH    per bit: 1 for the cycle after that bit's q changed
//  sr_err   out  1        sticky: SR mode saw S=R=1 on some bit while en=1
//  chg_cnt  out  CNT_W    count of enabled edges where q changed (saturating)
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides all other inputs):
//   q=RESET_VAL, qb=~RESET_VAL, chg=0, sr_err=0, chg_cnt=0.
//  Next state per bit i at each rising edge with en=1, rst=0 (1-cycle latency):
//   JK: 00 hold, 01 ->0, 10 ->1, 11 toggle
//   SR: 00 hold, 01 ->0 (R), 10 ->1 (S), 11 hold and set sr_err
//   D : q<=a[i]
//   T : a[i]=1 toggle, else hold
//  Enable:
//   - en=0: q, qb, chg_cnt hold; chg<=0; sr_err not set.
//   - Mode changes take effect on the same edge; no pipeline.
//  Change tracking:
//   - chg[i]<=(q_next[i]!=q[i]).
//   - chg_cnt increments by 1 when any chg bit is being set this edge.
//   - chg_cnt saturates at 2^CNT_W-1 (no wrap).
//  Error flag:
//   - sr_err set if mode=SR, en=1 and any bit has a&b=1.
//   - Set has priority over err_clr on the same edge.
//   - err_clr acts regardless of en.
//  Reset mid-operation discards the in-flight update; the first post-reset
//  edge behaves from RESET_VAL. No X on any output after the first reset edge.
// TESTING
//  1. rst=1 with WIDTH=8, RESET_VAL=8'hA5 -> q=A5, qb=5A, chg=0, sr_err=0, chg_cnt=0.
//  2. JK mode, a=8'hF0, b=8'h0F, then a=b=8'hFF -> q=F0, then q=0F; chg=FF both times.
//  3. SR mode from q=00, a=8'h01, b=8'h01 -> q=00, sr_err=1 next cycle.
//     Then err_clr=1 alongside a=b=01 -> sr_err stays 1.
//     Then err_clr=1 with a=b=0 -> sr_err=0.
//  4. T mode, a=8'h01, 300 edges with CNT_W=8 -> q[0] alternates,
//     chg_cnt stops at 255 and does not wrap.
//  5. D mode, en=0, a=8'h3C -> q, chg_cnt unchanged, chg=0. en=1 -> q=3C on the next edge.
//  6. rst asserted mid T-mode toggling -> q=RESET_VAL on that edge.
//     Toggling resumes from RESET_VAL and chg_cnt restarts from 0.

Source files
------------

// File: rtl/jk_ff_bank.sv
// ============================================================================
// Module      : jk_ff_bank
// Description : WIDTH-bit bank of universal flip-flops (JK/SR/D/T runtime
//               mode) with clock enable, change flags, sticky SR-illegal
//               error and a saturating change counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] chg,
  output logic             sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [1:0] c_MODE_JK = 2'b00;
  localparam logic [1:0] c_MODE_SR = 2'b01;
  localparam logic [1:0] c_MODE_D  = 2'b10;
  localparam logic [1:0] c_MODE_T  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic             r_sr_err;
  logic [CNT_W-1:0] r_chg_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_diff;
  logic             w_sr_illegal;
  logic             w_cnt_full;

  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode)
        c_MODE_JK: begin
          case ({a[i], b[i]})
            2'b01:   w_q_next[i] = 1'b0;
            2'b10:   w_q_next[i] = 1'b1;
            2'b11:   w_q_next[i] = ~r_q[i];
            default: w_q_next[i] = r_q[i];
          endcase
        end
        c_MODE_SR: begin
          // S=R=1 holds the bit; the illegal combination is flagged separately
          case ({a[i], b[i]})
            2'b01:   w_q_next[i] = 1'b0;
            2'b10:   w_q_next[i] = 1'b1;
            default: w_q_next[i] = r_q[i];
          endcase
        end
        c_MODE_D: w_q_next[i] = a[i];
        c_MODE_T: w_q_next[i] = a[i] ? ~r_q[i] : r_q[i];
        default:  w_q_next[i] = r_q[i];
      endcase
    end
  end

  assign w_diff       = w_q_next ^ r_q;
  assign w_sr_illegal = (mode == c_MODE_SR) && (|(a & b));
  assign w_cnt_full   = (r_chg_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= RESET_VAL;
      r_chg     <= '0;
      r_sr_err  <= 1'b0;
      r_chg_cnt <= '0;
    end else begin
      if (en) begin
        r_q   <= w_q_next;
        r_chg <= w_diff;
        if ((|w_diff) && !w_cnt_full) begin
          r_chg_cnt <= r_chg_cnt + 1'b1;
        end
      end else begin
        r_chg <= '0;
      end
      // A new error on this edge wins over a simultaneous clear
      if (en && w_sr_illegal) begin
        r_sr_err <= 1'b1;
      end else if (err_clr) begin
        r_sr_err <= 1'b0;
      end
    end
  end

  assign q       = r_q;
  assign qb      = ~r_q;
  assign chg     = r_chg;
  assign sr_err  = r_sr_err;
  assign chg_cnt = r_chg_cnt;

endmodule

`default_nettype wire

// File: tb/tb_jk_ff_bank.sv
// ============================================================================
// Module      : tb_jk_ff_bank
// Description : Scoreboard testbench for jk_ff_bank (WIDTH=8, RESET_VAL=A5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_ff_bank;

  localparam int         WIDTH     = 8;
  localparam logic [7:0] RESET_VAL = 8'hA5;
  localparam int         CNT_W     = 8;
  localparam logic [1:0] c_JK = 2'b00, c_SR = 2'b01, c_D = 2'b10, c_T = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] q, qb, chg;
  logic             sr_err;
  logic [CNT_W-1:0] chg_cnt;

  jk_ff_bank #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q), .qb(qb), .chg(chg), .sr_err(sr_err),
    .chg_cnt(chg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] chg;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_chg;
  logic             m_err;
  int               m_cnt;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic logic next_bit(input logic [1:0] md, input logic qi, input logic ai, input logic bi);
    logic r;
    r = qi;
    if (md == c_D) r = ai;
    else if (md == c_T) begin
      if (ai) r = !qi;
    end else if (md == c_JK) begin
      if (ai && !bi) r = 1'b1;
      else if (!ai && bi) r = 1'b0;
      else if (ai && bi) r = !qi;
    end else begin
      if (ai && !bi) r = 1'b1;
      else if (!ai && bi) r = 1'b0;
    end
    return r;
  endfunction

  // Drive one cycle of stimulus, update the model, push the expectation,
  // then pop and compare once the DUT has taken the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic clr);
    exp_t ex, got;
    logic [WIDTH-1:0] nq;
    logic illegal;
    @(negedge clk);
    rst = r; en = e; mode = md; a = av; b = bv; err_clr = clr;
    if (r) begin
      m_q = RESET_VAL; m_chg = '0; m_err = 1'b0; m_cnt = 0;
    end else begin
      illegal = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        nq[i] = next_bit(md, m_q[i], av[i], bv[i]);
        if (md == c_SR && av[i] && bv[i]) illegal = 1'b1;
      end
      if (e) begin
        m_chg = nq ^ m_q;
        if (m_chg != 0 && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        m_q = nq;
      end else begin
        m_chg = '0;
      end
      if (e && illegal) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    ex.q = m_q; ex.chg = m_chg; ex.err = m_err; ex.cnt = m_cnt[CNT_W-1:0];
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("q",       {24'd0, q},       {24'd0, got.q});
    check("qb",      {24'd0, qb},      {24'd0, ~got.q});
    check("chg",     {24'd0, chg},     {24'd0, got.chg});
    check("sr_err",  {31'd0, sr_err},  {31'd0, got.err});
    check("chg_cnt", {24'd0, chg_cnt}, {24'd0, got.cnt});
  endtask

  initial begin
    m_q = '0; m_chg = '0; m_err = 1'b0; m_cnt = 0;

    // Reset overrides other inputs
    step(1, 1, c_JK, 8'hFF, 8'hFF, 1);
    check("reset_q", {24'd0, q}, 32'hA5);
    check("reset_qb", {24'd0, qb}, 32'h5A);

    // JK set/reset then toggle from 0F
    step(0, 1, c_D, 8'h0F, 8'h00, 0);
    step(0, 1, c_JK, 8'hF0, 8'h0F, 0);
    check("jk_q1", {24'd0, q}, 32'hF0);
    check("jk_chg1", {24'd0, chg}, 32'hFF);
    step(0, 1, c_JK, 8'hFF, 8'hFF, 0);
    check("jk_q2", {24'd0, q}, 32'h0F);
    check("jk_chg2", {24'd0, chg}, 32'hFF);

    // SR illegal, set-over-clear priority, then clear
    step(0, 1, c_D, 8'h00, 8'h00, 0);
    step(0, 1, c_SR, 8'h01, 8'h01, 0);
    check("sr_hold", {24'd0, q}, 32'h00);
    check("sr_err_set", {31'd0, sr_err}, 32'd1);
    step(0, 1, c_SR, 8'h01, 8'h01, 1);
    check("sr_err_prio", {31'd0, sr_err}, 32'd1);
    step(0, 0, c_SR, 8'h00, 8'h00, 1);
    check("sr_err_clr", {31'd0, sr_err}, 32'd0);
    // Illegal pattern while disabled must not set the flag
    step(0, 0, c_SR, 8'hFF, 8'hFF, 0);
    check("sr_err_en0", {31'd0, sr_err}, 32'd0);

    // Counter saturation in T mode
    step(1, 0, c_T, 8'h00, 8'h00, 0);
    for (int i = 0; i < 300; i++) step(0, 1, c_T, 8'h01, 8'h00, 0);
    check("cnt_sat", {24'd0, chg_cnt}, 32'd255);

    // D mode with enable low, then high
    step(0, 0, c_D, 8'h3C, 8'h00, 0);
    check("en0_cnt", {24'd0, chg_cnt}, 32'd255);
    check("en0_chg", {24'd0, chg}, 32'd0);
    step(0, 1, c_D, 8'h3C, 8'h00, 0);
    check("d_load", {24'd0, q}, 32'h3C);

    // Reset mid toggling, then resume
    for (int i = 0; i < 5; i++) step(0, 1, c_T, 8'h81, 8'h00, 0);
    step(1, 1, c_T, 8'h81, 8'h00, 0);
    check("mid_rst_q", {24'd0, q}, 32'hA5);
    check("mid_rst_cnt", {24'd0, chg_cnt}, 32'd0);
    step(0, 1, c_T, 8'h01, 8'h00, 0);
    check("resume_q", {24'd0, q}, 32'hA4);
    check("resume_cnt", {24'd0, chg_cnt}, 32'd1);

    // Random mix of all modes and controls
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) == 0));
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running expected=done");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
